// File: rtl/d_sram_to_sram_like_if.sv
// SRAM-like split-handshake data bus (req/addr_ok, then data_ok).
interface d_sram_to_sram_like_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;

  // Bridge side drives the request, slave answers with handshakes and data.
  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/d_sram_to_sram_like.sv
// Data-side bridge: pipeline SRAM port -> SRAM-like split-handshake bus.
// Holds the pipeline until data_ok, keeps read data until the global stall
// releases, and optionally flags a slave that never answers.
module d_sram_to_sram_like #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 0,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_sram_en,
  input  logic [3:0]            data_sram_wen,
  input  logic [ADDR_W-1:0]     data_sram_addr,
  input  logic [31:0]           data_sram_wdata,
  output logic [31:0]           data_sram_rdata,
  output logic                  d_stall,
  input  logic                  all_stall,
  d_sram_to_sram_like_if.master bus,
  output logic                  size_err,
  output logic                  timeout_err
);

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_WAIT_DATA = 2'd1;
  localparam logic [1:0] S_DONE      = 2'd2;

  localparam bit               WD_EN    = (TIMEOUT_CYC != 0);
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [1:0]       state_q, state_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             timeout_err_q, timeout_err_d;
  logic             accept_data;
  logic             wd_wait;

  // Address/data pass straight through; the stall keeps them stable.
  assign bus.data_addr   = data_sram_addr;
  assign bus.data_wdata  = data_sram_wdata;
  assign bus.data_wr     = |data_sram_wen;
  assign bus.data_req    = (state_q == S_IDLE) & data_sram_en;
  assign d_stall         = data_sram_en & (state_q != S_DONE);
  assign data_sram_rdata = rdata_q;
  assign timeout_err     = timeout_err_q;

  // Transfer size from the byte-enable pattern; odd patterns fall back to word.
  always_comb begin
    bus.data_size = 2'd2;
    size_err      = 1'b0;
    case (data_sram_wen)
      4'b0000, 4'b1111:                   bus.data_size = 2'd2;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: bus.data_size = 2'd0;
      4'b0011, 4'b1100:                   bus.data_size = 2'd1;
      default: begin
        bus.data_size = 2'd2;
        size_err      = 1'b1;
      end
    endcase
  end

  // Next state; data_ok wins over addr_ok when both land in IDLE.
  always_comb begin
    state_d     = state_q;
    accept_data = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (data_sram_en && bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            state_d     = S_DONE;
            accept_data = 1'b1;
          end else begin
            state_d = S_WAIT_DATA;
          end
        end
      end
      S_WAIT_DATA: begin
        if (bus.data_data_ok) begin
          state_d     = S_DONE;
          accept_data = 1'b1;
        end
      end
      S_DONE: begin
        if (!all_stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture read data only for a response that belongs to an accepted read.
  always_comb begin
    rdata_d = rdata_q;
    if (accept_data && !bus.data_wr) rdata_d = bus.data_rdata;
  end

  // Watchdog: count waiting cycles, saturate at the limit, sticky error flag.
  assign wd_wait = ((state_q == S_IDLE) & bus.data_req & ~bus.data_addr_ok) |
                   ((state_q == S_WAIT_DATA) & ~bus.data_data_ok);

  always_comb begin
    wd_cnt_d      = '0;
    timeout_err_d = 1'b0;
    if (WD_EN) begin
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = timeout_err_q;
      if (state_d == S_DONE && state_q != S_DONE) begin
        wd_cnt_d = '0;
      end else if (wd_wait && wd_cnt_q != WD_LIMIT) begin
        wd_cnt_d = wd_cnt_q + CNT_W'(1);
      end
      if (wd_cnt_d == WD_LIMIT) timeout_err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rdata_q       <= '0;
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rdata_q       <= rdata_d;
      wd_cnt_q      <= wd_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

endmodule

// File: tb/tb_d_sram_to_sram_like.sv
// Directed bench for d_sram_to_sram_like (watchdog built with an 8-cycle limit).
module tb_d_sram_to_sram_like;

  logic        clk;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] sram_rdata;
  logic        d_stall;
  logic        all_stall;
  logic        size_err;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  d_sram_to_sram_like_if #(.ADDR_W(32)) bus_if ();

  d_sram_to_sram_like #(
    .ADDR_W(32),
    .TIMEOUT_CYC(8),
    .CNT_W(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_sram_en   (en),
    .data_sram_wen  (wen),
    .data_sram_addr (addr),
    .data_sram_wdata(wdata),
    .data_sram_rdata(sram_rdata),
    .d_stall        (d_stall),
    .all_stall      (all_stall),
    .bus            (bus_if),
    .size_err       (size_err),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    en = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    en = 1'b0; wen = 4'b0000; addr = 32'h0; wdata = 32'h0; all_stall = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    @(negedge clk);
    total++; if (sram_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=00000000", sram_rdata); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b want=0", timeout_err); end
    total++; if (bus_if.data_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", bus_if.data_req); end
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", d_stall); end
    rst = 1'b1;
    tick();
  endtask

  // addr_ok in cycle 0, data_ok in cycle 2
  task automatic test_read_split();
    logic [3:0] e_req;
    logic [3:0] e_stall;
    e_req   = 4'b0001;
    e_stall = 4'b0111;
    for (int c = 0; c < 4; c++) begin
      en = 1'b1; wen = 4'b0000; addr = 32'h0000_1000;
      bus_if.data_addr_ok = (c == 0);
      bus_if.data_data_ok = (c == 2);
      bus_if.data_rdata   = (c == 2) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      total++; if (bus_if.data_req !== e_req[c]) begin bad++; $display("FAIL split_req c=%0d got=%b want=%b", c, bus_if.data_req, e_req[c]); end
      total++; if (d_stall !== e_stall[c]) begin bad++; $display("FAIL split_stall c=%0d got=%b want=%b", c, d_stall, e_stall[c]); end
      if (c == 0) begin
        total++; if (bus_if.data_wr !== 1'b0) begin bad++; $display("FAIL split_wr got=%b want=0", bus_if.data_wr); end
        total++; if (bus_if.data_size !== 2'd2) begin bad++; $display("FAIL split_size got=%0d want=2", bus_if.data_size); end
        total++; if (bus_if.data_addr !== 32'h0000_1000) begin bad++; $display("FAIL split_addr got=%h want=00001000", bus_if.data_addr); end
      end
      if (c == 3) begin
        total++; if (sram_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL split_rdata got=%h want=deadbeef", sram_rdata); end
      end
      tick();
    end
    idle_cyc();
  endtask

  task automatic test_read_same_cycle();
    en = 1'b1; wen = 4'b0000; addr = 32'h0000_1004;
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h1234_5678;
    @(negedge clk);
    total++; if (bus_if.data_req !== 1'b1) begin bad++; $display("FAIL same_req0 got=%b want=1", bus_if.data_req); end
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL same_stall0 got=%b want=1", d_stall); end
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    @(negedge clk);
    total++; if (bus_if.data_req !== 1'b0) begin bad++; $display("FAIL same_req1 got=%b want=0", bus_if.data_req); end
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL same_stall1 got=%b want=0", d_stall); end
    total++; if (sram_rdata !== 32'h1234_5678) begin bad++; $display("FAIL same_rdata got=%h want=12345678", sram_rdata); end
    tick();
    idle_cyc();
  endtask

  task automatic test_writes();
    logic [3:0] t_wen  [4];
    logic [1:0] t_size [4];
    logic       t_err  [4];
    t_wen[0] = 4'b0010; t_size[0] = 2'd0; t_err[0] = 1'b0;
    t_wen[1] = 4'b1100; t_size[1] = 2'd1; t_err[1] = 1'b0;
    t_wen[2] = 4'b1111; t_size[2] = 2'd2; t_err[2] = 1'b0;
    t_wen[3] = 4'b0101; t_size[3] = 2'd2; t_err[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      en = 1'b1; wen = t_wen[i];
      addr  = 32'h0000_2000 + 32'(i * 4);
      wdata = 32'hA5A5_0000 + 32'(i);
      bus_if.data_addr_ok = 1'b1;
      bus_if.data_data_ok = 1'b1;
      bus_if.data_rdata   = 32'hBAD0_BAD0;
      @(negedge clk);
      total++; if (bus_if.data_wr !== 1'b1) begin bad++; $display("FAIL wr_flag i=%0d got=%b want=1", i, bus_if.data_wr); end
      total++; if (bus_if.data_size !== t_size[i]) begin bad++; $display("FAIL wr_size i=%0d got=%0d want=%0d", i, bus_if.data_size, t_size[i]); end
      total++; if (size_err !== t_err[i]) begin bad++; $display("FAIL wr_size_err i=%0d got=%b want=%b", i, size_err, t_err[i]); end
      total++; if (bus_if.data_wdata !== 32'hA5A5_0000 + 32'(i)) begin bad++; $display("FAIL wr_wdata i=%0d got=%h", i, bus_if.data_wdata); end
      total++; if (bus_if.data_req !== 1'b1) begin bad++; $display("FAIL wr_req i=%0d got=%b want=1", i, bus_if.data_req); end
      tick();
      bus_if.data_addr_ok = 1'b0;
      bus_if.data_data_ok = 1'b0;
      @(negedge clk);
      total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL wr_done_stall i=%0d got=%b want=0", i, d_stall); end
      total++; if (sram_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wr_keep_rdata i=%0d got=%h want=12345678", i, sram_rdata); end
      tick();
      idle_cyc();
    end
    wen = 4'b0000;
  endtask

  task automatic test_stall_hold();
    en = 1'b1; wen = 4'b0000; addr = 32'h0000_3000; all_stall = 1'b1;
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b0;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hCAFE_F00D;
    tick();
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL hold_stall c=%0d got=%b want=0", c, d_stall); end
      total++; if (bus_if.data_req !== 1'b0) begin bad++; $display("FAIL hold_req c=%0d got=%b want=0", c, bus_if.data_req); end
      total++; if (sram_rdata !== 32'hCAFE_F00D) begin bad++; $display("FAIL hold_rdata c=%0d got=%h want=cafef00d", c, sram_rdata); end
      tick();
    end
    all_stall = 1'b0;
    @(negedge clk);
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL release_stall got=%b want=0", d_stall); end
    tick();
    // back in IDLE with en still high: a fresh request goes out
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h0F0F_0F0F;
    @(negedge clk);
    total++; if (bus_if.data_req !== 1'b1) begin bad++; $display("FAIL reissue_req got=%b want=1", bus_if.data_req); end
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL reissue_stall got=%b want=1", d_stall); end
    tick();
    en = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    @(negedge clk);
    total++; if (sram_rdata !== 32'h0F0F_0F0F) begin bad++; $display("FAIL reissue_rdata got=%h want=0f0f0f0f", sram_rdata); end
    tick();
    idle_cyc();
  endtask

  task automatic test_timeout();
    @(negedge clk);
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_clean got=%b want=0", timeout_err); end
    tick();
    en = 1'b1; wen = 4'b0000; addr = 32'h0000_4000;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 7) begin
        total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL wd_early got=%b want=0", timeout_err); end
      end
      if (c >= 8) begin
        total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_raise c=%0d got=%b want=1", c, timeout_err); end
      end
      tick();
    end
    bus_if.data_addr_ok = 1'b1;
    tick();
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h55AA_55AA;
    tick();
    bus_if.data_data_ok = 1'b0;
    @(negedge clk);
    total++; if (sram_rdata !== 32'h55AA_55AA) begin bad++; $display("FAIL wd_late_rdata got=%h want=55aa55aa", sram_rdata); end
    total++; if (d_stall !== 1'b0) begin bad++; $display("FAIL wd_late_stall got=%b want=0", d_stall); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL wd_sticky got=%b want=1", timeout_err); end
    tick();
    idle_cyc();
  endtask

  task automatic test_reset_mid();
    en = 1'b1; wen = 4'b0000; addr = 32'h0000_5000;
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b0;
    tick();
    bus_if.data_addr_ok = 1'b0;
    @(negedge clk);
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL mid_wait_stall got=%b want=1", d_stall); end
    #1;
    rst = 1'b0;
    en  = 1'b0;
    #1;
    total++; if (bus_if.data_req !== 1'b0) begin bad++; $display("FAIL mid_rst_req got=%b want=0", bus_if.data_req); end
    total++; if (sram_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata got=%h want=00000000", sram_rdata); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL mid_rst_timeout got=%b want=0", timeout_err); end
    @(negedge clk);
    rst = 1'b1;
    tick();
    // stale response with nothing accepted
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'hFFFF_FFFF;
    tick();
    bus_if.data_data_ok = 1'b0;
    bus_if.data_rdata   = 32'h0;
    en = 1'b1;
    @(negedge clk);
    total++; if (sram_rdata !== 32'h0) begin bad++; $display("FAIL stale_rdata got=%h want=00000000", sram_rdata); end
    total++; if (bus_if.data_req !== 1'b1) begin bad++; $display("FAIL stale_idle_req got=%b want=1", bus_if.data_req); end
    total++; if (d_stall !== 1'b1) begin bad++; $display("FAIL stale_idle_stall got=%b want=1", d_stall); end
    tick();
    bus_if.data_addr_ok = 1'b1;
    bus_if.data_data_ok = 1'b1;
    bus_if.data_rdata   = 32'h1357_9BDF;
    tick();
    en = 1'b0;
    bus_if.data_addr_ok = 1'b0;
    bus_if.data_data_ok = 1'b0;
    @(negedge clk);
    total++; if (sram_rdata !== 32'h1357_9BDF) begin bad++; $display("FAIL post_rst_rdata got=%h want=13579bdf", sram_rdata); end
    tick();
    idle_cyc();
  endtask

  initial begin
    test_reset();
    test_read_split();
    test_read_same_cycle();
    test_writes();
    test_stall_hold();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
